// File: rtl/hazard3_break_sequencer.sv
// Breakpoint request sequencer: turns trigger-unit break requests on the execute-stage
// instruction into a held trap request, then steps over the trapping PC once on return.
module hazard3_break_sequencer #(
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              break_any,
    input  logic              break_d_mode,
    input  logic              x_valid,
    input  logic [W_ADDR-1:0] x_pc,
    input  logic              x_advance,
    input  logic              x_flush,
    input  logic              trap_ack,
    input  logic              trap_return,
    output logic              x_suppress,
    output logic              trap_req,
    output logic              trap_d_mode,
    output logic [3:0]        trap_cause,
    output logic [W_ADDR-1:0] trap_pc,
    output logic              break_pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2,
        SKIP    = 2'd3
    } state_t;

    state_t            state_r;
    logic              trap_req_r;
    logic              trap_d_mode_r;
    logic [3:0]        trap_cause_r;
    logic [W_ADDR-1:0] trap_pc_r;
    logic              break_pending_r;

    logic              inhibit_s;
    logic              match_s;
    logic              retire_s;

    // Match qualification; a request already in flight masks any new trigger hit.
    always_comb begin
        inhibit_s  = (state_r == SKIP) && (x_pc == trap_pc_r);
        match_s    = x_valid && break_any && !x_flush && !inhibit_s && (state_r != REQ);
        retire_s   = x_valid && x_advance && !x_flush;
        x_suppress = match_s || (state_r == REQ);
    end

    // Sequencer FSM with registered trap request and capture of cause/mode/PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            trap_req_r      <= 1'b0;
            trap_d_mode_r   <= 1'b0;
            trap_cause_r    <= 4'd0;
            trap_pc_r       <= {W_ADDR{1'b0}};
            break_pending_r <= 1'b0;
        end else if (match_s) begin
            // A fresh match takes priority over trap_return and over retirement in SKIP.
            state_r         <= REQ;
            trap_req_r      <= 1'b1;
            trap_d_mode_r   <= break_d_mode;
            trap_cause_r    <= break_d_mode ? 4'd2 : 4'd3;
            trap_pc_r       <= x_pc;
            break_pending_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                REQ: begin
                    if (trap_ack) begin
                        state_r    <= HANDLER;
                        trap_req_r <= 1'b0;
                    end
                end
                HANDLER: begin
                    if (trap_return) begin
                        state_r         <= SKIP;
                        break_pending_r <= 1'b0;
                    end
                end
                SKIP: begin
                    if (retire_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    trap_req_r      <= 1'b0;
                    break_pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign trap_req      = trap_req_r;
    assign trap_d_mode   = trap_d_mode_r;
    assign trap_cause    = trap_cause_r;
    assign trap_pc       = trap_pc_r;
    assign break_pending = break_pending_r;

endmodule

// File: tb/tb_hazard3_break_sequencer.sv
// Scoreboard bench for hazard3_break_sequencer: expected trap records are queued when a
// breaking instruction is presented and compared when trap_req rises.
module tb_hazard3_break_sequencer;

    logic        clk;
    logic        rst;
    logic        break_any;
    logic        break_d_mode;
    logic        x_valid;
    logic [31:0] x_pc;
    logic        x_advance;
    logic        x_flush;
    logic        trap_ack;
    logic        trap_return;
    logic        x_suppress;
    logic        trap_req;
    logic        trap_d_mode;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic        break_pending;

    int checks_s;
    int failures_s;

    typedef struct {
        logic [31:0] pc;
        logic        d_mode;
        logic [3:0]  cause;
    } trap_exp_t;

    trap_exp_t exp_q[$];

    hazard3_break_sequencer #(.W_ADDR(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .break_any     (break_any),
        .break_d_mode  (break_d_mode),
        .x_valid       (x_valid),
        .x_pc          (x_pc),
        .x_advance     (x_advance),
        .x_flush       (x_flush),
        .trap_ack      (trap_ack),
        .trap_return   (trap_return),
        .x_suppress    (x_suppress),
        .trap_req      (trap_req),
        .trap_d_mode   (trap_d_mode),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .break_pending (break_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            failures_s++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction that a trigger matches, and queue the trap it must raise.
    task automatic present_break(input logic [31:0] pc, input logic d_mode);
        trap_exp_t e;
        x_valid      = 1'b1;
        x_pc         = pc;
        break_any    = 1'b1;
        break_d_mode = d_mode;
        x_advance    = 1'b1;
        #1;
        check_val("suppress_on_match", {31'd0, x_suppress}, 32'd1);
        e.pc     = pc;
        e.d_mode = d_mode;
        e.cause  = d_mode ? 4'd2 : 4'd3;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for trap_req and compare against the oldest queued expectation.
    task automatic wait_trap();
        trap_exp_t e;
        int waited;
        waited = 0;
        step();
        waited = 1;
        break_any = 1'b0;
        while (!trap_req && waited < 8) begin
            step();
            waited++;
        end
        check_val("trap_req_latency", waited, 32'd1);
        check_val("trap_req_raised", {31'd0, trap_req}, 32'd1);
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("trap_pc", trap_pc, e.pc);
            check_val("trap_d_mode", {31'd0, trap_d_mode}, {31'd0, e.d_mode});
            check_val("trap_cause", {28'd0, trap_cause}, {28'd0, e.cause});
            check_val("pending_in_req", {31'd0, break_pending}, 32'd1);
        end
    endtask

    task automatic ack_trap();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check_val("req_drop_on_ack", {31'd0, trap_req}, 32'd0);
        check_val("pending_in_handler", {31'd0, break_pending}, 32'd1);
    endtask

    task automatic do_return();
        trap_return = 1'b1;
        step();
        trap_return = 1'b0;
        check_val("pending_after_return", {31'd0, break_pending}, 32'd0);
    endtask

    // Retire one plain instruction (no trigger), leaving SKIP for IDLE.
    task automatic retire_plain(input logic [31:0] pc);
        x_valid   = 1'b1;
        x_pc      = pc;
        break_any = 1'b0;
        x_advance = 1'b1;
        #1;
        check_val("plain_no_suppress", {31'd0, x_suppress}, 32'd0);
        step();
        check_val("plain_no_req", {31'd0, trap_req}, 32'd0);
    endtask

    initial begin
        checks_s     = 0;
        failures_s   = 0;
        rst          = 1'b1;
        break_any    = 1'b0;
        break_d_mode = 1'b0;
        x_valid      = 1'b0;
        x_pc         = 32'd0;
        x_advance    = 1'b0;
        x_flush      = 1'b0;
        trap_ack     = 1'b0;
        trap_return  = 1'b0;
        step();
        step();
        check_val("rst_trap_req", {31'd0, trap_req}, 32'd0);
        check_val("rst_trap_pc", trap_pc, 32'd0);
        check_val("rst_trap_cause", {28'd0, trap_cause}, 32'd0);
        check_val("rst_pending", {31'd0, break_pending}, 32'd0);
        rst = 1'b0;
        step();
        step();

        // Ack and return outside their states are ignored.
        trap_ack    = 1'b1;
        trap_return = 1'b1;
        step();
        trap_ack    = 1'b0;
        trap_return = 1'b0;
        check_val("idle_ack_ignored", {31'd0, break_pending}, 32'd0);

        // 1: M-mode trap held until ack.
        present_break(32'h100, 1'b0);
        wait_trap();
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_req", {31'd0, trap_req}, 32'd1);
            check_val("hold_pc", trap_pc, 32'h100);
            check_val("hold_cause", {28'd0, trap_cause}, 32'd3);
            check_val("hold_suppress", {31'd0, x_suppress}, 32'd1);
        end
        ack_trap();
        do_return();
        retire_plain(32'h104);

        // 2: D-mode trap, then step over the same PC once, then it fires again.
        present_break(32'h2000, 1'b1);
        wait_trap();
        ack_trap();
        do_return();
        x_pc      = 32'h2000;
        break_any = 1'b1;
        x_advance = 1'b1;
        #1;
        check_val("skip_inhibit", {31'd0, x_suppress}, 32'd0);
        step();
        check_val("skip_no_req", {31'd0, trap_req}, 32'd0);
        check_val("skip_pending", {31'd0, break_pending}, 32'd0);
        present_break(32'h2000, 1'b1);
        wait_trap();
        ack_trap();
        do_return();

        // 3: different PC while stepping over is taken normally.
        present_break(32'h300, 1'b0);
        wait_trap();
        ack_trap();

        // 5: nested D-mode break in handler overrides trap_return.
        trap_return = 1'b1;
        present_break(32'h80, 1'b1);
        wait_trap();
        trap_return = 1'b0;
        ack_trap();
        do_return();
        retire_plain(32'h84);

        // 4: flushed match is not taken; flush during REQ does not cancel.
        x_flush   = 1'b1;
        x_pc      = 32'h400;
        break_any = 1'b1;
        #1;
        check_val("flush_no_suppress", {31'd0, x_suppress}, 32'd0);
        step();
        check_val("flush_no_req", {31'd0, trap_req}, 32'd0);
        x_flush = 1'b0;
        present_break(32'h400, 1'b0);
        wait_trap();
        x_flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("flush_in_req", {31'd0, trap_req}, 32'd1);
        end
        x_flush = 1'b0;
        ack_trap();
        do_return();
        retire_plain(32'h404);

        // 6: asynchronous reset mid-request.
        present_break(32'h500, 1'b0);
        wait_trap();
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_req", {31'd0, trap_req}, 32'd0);
        check_val("async_rst_pc", trap_pc, 32'd0);
        check_val("async_rst_pending", {31'd0, break_pending}, 32'd0);
        x_valid   = 1'b0;
        break_any = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("post_rst_req", {31'd0, trap_req}, 32'd0);
            check_val("post_rst_pending", {31'd0, break_pending}, 32'd0);
        end
        check_val("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
